// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine and its register/AXI wrapper.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH = 32;
  localparam int unsigned GCD_CYC_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_core.sv
// Iterative subtract-or-swap Euclidean GCD engine with valid/ready request and response ports.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH,
  parameter int unsigned CYC_W = GCD_CYC_W
) (
  input  logic             CLK,
  input  logic             CLKEN,
  input  logic             RESETn,
  input  logic             ABORT,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] REQ_A,
  input  logic [WIDTH-1:0] REQ_B,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_GCD,
  output logic [CYC_W-1:0] RSP_CYCLES,
  output logic             DONE_PULSE,
  output logic             BUSY
);

  localparam logic [CYC_W-1:0] CycOne = CYC_W'(1);
  localparam logic [CYC_W-1:0] CycMax = '1;

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    cyc_d   = cyc_q;
    pulse_d = 1'b0;
    // Abort wins over both handshakes in the same cycle.
    if (ABORT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ_VALID) begin
            a_d     = REQ_A;
            b_d     = REQ_B;
            cyc_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          if (cyc_q != CycMax) cyc_d = cyc_q + CycOne;
          if (b_q == '0) begin
            gcd_d   = a_q;
            pulse_d = 1'b1;
            state_d = DONE;
          end else if (a_q < b_q) begin
            a_d = b_q;
            b_d = a_q;
          end else begin
            a_d = a_q - b_q;
          end
        end
        DONE: begin
          if (RSP_READY) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      cyc_q   <= '0;
      pulse_q <= 1'b0;
    end else if (CLKEN) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      cyc_q   <= cyc_d;
      pulse_q <= pulse_d;
    end
  end

  assign REQ_READY  = (state_q == IDLE);
  assign RSP_VALID  = (state_q == DONE);
  assign BUSY       = (state_q == CALC);
  assign RSP_GCD    = gcd_q;
  assign RSP_CYCLES = cyc_q;
  assign DONE_PULSE = pulse_q;

endmodule
